rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
- Reservation station for the integer ALU, directly upstream of it.
- Holds dispatched arithmetic, branch and jump micro-ops until both source operands are available.
- Snoops the ALU and load/store common data buses to capture operands, then issues one ready entry per cycle.
- Issued ops reach the ALU on registered outputs, with a one-cycle new_calculate pulse.

Parameters:
RS_SIZE, 16, number of station entries (power of two, 2..32)
RS_IDX_W, 4, log2(RS_SIZE)
TAG_W, 4, ROB entry tag width (matches the ALU entry field)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze
clear  in  1  mispredict flush, synchronous
issue_valid  in  1  dispatch presents a new op this cycle
issue_instruction  in  32  raw instruction word (shamt source)
issue_op  in  6  decoded op code
issue_pc  in  32  instruction PC
issue_imm  in  32  sign-extended immediate
issue_entry  in  TAG_W  destination ROB tag
issue_qj_busy  in  1  rs1 operand still pending
issue_qj  in  TAG_W  producer tag of rs1 when pending
issue_vj  in  32  rs1 value when not pending
issue_qk_busy  in  1  rs2 operand still pending
issue_qk  in  TAG_W  producer tag of rs2
issue_vk  in  32  rs2 value
rs_full  out  1  no free entry (combinational)
alu_broadcast  in  1  ALU CDB valid
alu_result  in  32  ALU CDB value
alu_entry  in  TAG_W  ALU CDB tag
lsb_broadcast  in  1  load/store CDB valid
lsb_result  in  32  load/store CDB value
lsb_entry  in  TAG_W  load/store CDB tag
new_calculate  out  1  one-cycle issue strobe to ALU
instruction, op, vj, vk, pc, imm  out  32/6/32/32/32/32  issued op fields (registered)
entry  out  TAG_W  issued op ROB tag (registered)

Behaviour:
- Reset (rst=1 at posedge): all busy bits 0; new_calculate 0; every data output 0; rs_full 0.
- Per-entry state: busy, op fields, qj_busy/qj/vj, qk_busy/qk/vk.
- Dispatch: on posedge with issue_valid=1, the lowest-index free entry is written, busy=1.
  - Dispatch must not assert issue_valid while rs_full=1.
  - If asserted anyway, the request is dropped and no entry is corrupted.
- Same-cycle forwarding on dispatch: if issue_qj_busy and a CDB broadcasts tag issue_qj in that cycle, the entry stores the CDB value with qj_busy=0. Same rule for k.
- Wakeup: each busy entry with qj_busy=1 and a broadcast matching qj latches the value and clears qj_busy. Same rule for k.
  - If both CDBs carry the same tag in one cycle (illegal), the ALU bus wins.
- Select: among entries with busy=1, qj_busy=0 and qk_busy=0 at the start of the cycle, the lowest index is chosen.
  - At posedge the chosen entry's fields load into the output registers, new_calculate=1 and the entry's busy clears.
  - No ready entry: new_calculate=0 and the data outputs hold their previous values.
- Throughput: at most one issue per cycle.
- Latency:
  - Dispatch of an already-ready op at edge N gives new_calculate=1 after edge N+1.
  - Wakeup at edge N makes the entry eligible at edge N+1.
- Slot reuse: a slot freed by issue at edge N is reusable by dispatch at edge N+1. rs_full reflects only register state at the start of the cycle.
- Simultaneous dispatch and issue are allowed in the same cycle on different slots.
- new_calculate is a single-cycle pulse. The ALU broadcasts combinationally off it, so the RS snoops its own result the same cycle.
- clear=1 (priority below rst, above everything else): all busy bits 0; new_calculate 0 next cycle; concurrent dispatch discarded; data outputs hold.
- rdy=0 (clear and rst low): no state change, no dispatch accepted, no wakeup latched, new_calculate forced 0 next cycle.
  - Upstream stages freeze under the same rdy, so no broadcast is lost.
- Fill: rs_full=1 exactly when all RS_SIZE busy bits are set.

Test Plan:
- Ready ADDI dispatched with vj=5, imm=7, entry=3: one cycle later new_calculate=1 with op/vj/imm/entry passed through; the ALU then broadcasts 12 on tag 3. Next cycle new_calculate=0.
- ADD with qj pending on tag 2 and vk=1: no issue. After alu_broadcast tag 2 value 9, the entry issues the following cycle with vj=9, vk=1.
- Dispatch qk pending on tag 6 while lsb_broadcast tag 6 value 0xDEAD in the same cycle: the entry stores vk=0xDEAD and issues the next cycle.
- Fill all 16 entries with ops pending on tag 1: rs_full=1; a stray issue_valid is ignored. Broadcasting tag 1 issues the entries in index order 0..15, one per cycle; rs_full falls after the first issue.
- clear asserted with 5 busy entries plus a concurrent dispatch: next cycle rs_full=0 and new_calculate=0. A later broadcast of their tags produces no issue.
- rdy low for 3 cycles while a ready entry exists: new_calculate stays 0. When rdy returns, the entry issues exactly once.

Source files
------------

// File: rtl/rs_alu_if.sv
// Bus bundle for the ALU reservation station.
//   Dispatch side : issue_* fields in, rs_full out.
//   Snoop side    : ALU and load/store common data buses in.
//   Issue side    : new_calculate strobe plus registered op fields out.
// slave  = the reservation station's view; master = the environment's view.
interface rs_alu_if #(
  parameter int TAG_W = 4
);
  logic             issue_valid;
  logic [31:0]      issue_instruction;
  logic [5:0]       issue_op;
  logic [31:0]      issue_pc;
  logic [31:0]      issue_imm;
  logic [TAG_W-1:0] issue_entry;
  logic             issue_qj_busy;
  logic [TAG_W-1:0] issue_qj;
  logic [31:0]      issue_vj;
  logic             issue_qk_busy;
  logic [TAG_W-1:0] issue_qk;
  logic [31:0]      issue_vk;
  logic             rs_full;

  logic             alu_broadcast;
  logic [31:0]      alu_result;
  logic [TAG_W-1:0] alu_entry;
  logic             lsb_broadcast;
  logic [31:0]      lsb_result;
  logic [TAG_W-1:0] lsb_entry;

  logic             new_calculate;
  logic [31:0]      instruction;
  logic [5:0]       op;
  logic [31:0]      vj;
  logic [31:0]      vk;
  logic [31:0]      pc;
  logic [31:0]      imm;
  logic [TAG_W-1:0] entry;

  modport slave (
    input  issue_valid, issue_instruction, issue_op, issue_pc, issue_imm, issue_entry,
           issue_qj_busy, issue_qj, issue_vj, issue_qk_busy, issue_qk, issue_vk,
           alu_broadcast, alu_result, alu_entry, lsb_broadcast, lsb_result, lsb_entry,
    output rs_full, new_calculate, instruction, op, vj, vk, pc, imm, entry
  );

  modport master (
    output issue_valid, issue_instruction, issue_op, issue_pc, issue_imm, issue_entry,
           issue_qj_busy, issue_qj, issue_vj, issue_qk_busy, issue_qk, issue_vk,
           alu_broadcast, alu_result, alu_entry, lsb_broadcast, lsb_result, lsb_entry,
    input  rs_full, new_calculate, instruction, op, vj, vk, pc, imm, entry
  );
endinterface

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU.
//   rs_alu_entry : one station slot; holds an op, snoops both CDBs for its
//                  pending operands, reports busy/ready.
//   rs_alu       : top. Ports: clk, rst (sync, active high), rdy (low =
//                  freeze), clear (flush), bus (rs_alu_if.slave). Picks the
//                  lowest free slot for dispatch and the lowest ready slot for
//                  issue; issued fields go out on registers with a one-cycle
//                  new_calculate strobe.

module rs_alu_entry #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             wr_en,
  input  logic             iss_en,
  input  logic [31:0]      d_instruction,
  input  logic [5:0]       d_op,
  input  logic [31:0]      d_pc,
  input  logic [31:0]      d_imm,
  input  logic [TAG_W-1:0] d_entry,
  input  logic             d_qj_busy,
  input  logic [TAG_W-1:0] d_qj,
  input  logic [31:0]      d_vj,
  input  logic             d_qk_busy,
  input  logic [TAG_W-1:0] d_qk,
  input  logic [31:0]      d_vk,
  input  logic             alu_broadcast,
  input  logic [31:0]      alu_result,
  input  logic [TAG_W-1:0] alu_entry,
  input  logic             lsb_broadcast,
  input  logic [31:0]      lsb_result,
  input  logic [TAG_W-1:0] lsb_entry,
  output logic             busy,
  output logic             ready,
  output logic [31:0]      instruction,
  output logic [5:0]       op,
  output logic [31:0]      pc,
  output logic [31:0]      imm,
  output logic [TAG_W-1:0] entry,
  output logic [31:0]      vj,
  output logic [31:0]      vk
);
  logic             qj_busy, qk_busy;
  logic [TAG_W-1:0] qj, qk;

  // On dispatch the incoming tag is snooped (same-cycle forwarding),
  // otherwise the stored tag. The ALU bus wins a tag collision.
  logic [TAG_W-1:0] j_tag, k_tag;
  logic             j_alu, k_alu, j_hit, k_hit;
  logic [31:0]      j_val, k_val;

  assign j_tag = wr_en ? d_qj : qj;
  assign k_tag = wr_en ? d_qk : qk;
  assign j_alu = alu_broadcast && (alu_entry == j_tag);
  assign k_alu = alu_broadcast && (alu_entry == k_tag);
  assign j_hit = j_alu || (lsb_broadcast && (lsb_entry == j_tag));
  assign k_hit = k_alu || (lsb_broadcast && (lsb_entry == k_tag));
  assign j_val = j_alu ? alu_result : lsb_result;
  assign k_val = k_alu ? alu_result : lsb_result;

  assign ready = busy && !qj_busy && !qk_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      qj_busy <= 1'b0;
      qk_busy <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (rdy) begin
      if (wr_en) begin
        busy        <= 1'b1;
        instruction <= d_instruction;
        op          <= d_op;
        pc          <= d_pc;
        imm         <= d_imm;
        entry       <= d_entry;
        qj          <= d_qj;
        qk          <= d_qk;
        qj_busy     <= d_qj_busy && !j_hit;
        qk_busy     <= d_qk_busy && !k_hit;
        vj          <= (d_qj_busy && j_hit) ? j_val : d_vj;
        vk          <= (d_qk_busy && k_hit) ? k_val : d_vk;
      end else begin
        if (iss_en) busy <= 1'b0;
        if (busy && qj_busy && j_hit) begin
          vj      <= j_val;
          qj_busy <= 1'b0;
        end
        if (busy && qk_busy && k_hit) begin
          vk      <= k_val;
          qk_busy <= 1'b0;
        end
      end
    end
  end
endmodule

module rs_alu #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4,
  parameter int TAG_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  rs_alu_if.slave bus
);
  logic [RS_SIZE-1:0]            busy, ready, wr_en, iss_en;
  logic [RS_SIZE-1:0][31:0]      e_instruction, e_pc, e_imm, e_vj, e_vk;
  logic [RS_SIZE-1:0][5:0]       e_op;
  logic [RS_SIZE-1:0][TAG_W-1:0] e_entry;

  logic                sel_vld, free_vld;
  logic [RS_IDX_W-1:0] sel_idx, free_idx;

  // Lowest-index priority: scan downward so the last hit is the lowest.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_vld = 1'b1;
        sel_idx = RS_IDX_W'(i);
      end
      if (!busy[i]) begin
        free_vld = 1'b1;
        free_idx = RS_IDX_W'(i);
      end
    end
  end

  // A dispatch while full finds no free slot and is simply dropped.
  // Slot freed by this cycle's issue is not free yet, so the two never collide.
  always_comb begin
    wr_en  = '0;
    iss_en = '0;
    if (bus.issue_valid && free_vld) wr_en[free_idx] = 1'b1;
    if (sel_vld)                     iss_en[sel_idx] = 1'b1;
  end

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    rs_alu_entry #(.TAG_W(TAG_W)) u_ent (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .clear         (clear),
      .wr_en         (wr_en[g]),
      .iss_en        (iss_en[g]),
      .d_instruction (bus.issue_instruction),
      .d_op          (bus.issue_op),
      .d_pc          (bus.issue_pc),
      .d_imm         (bus.issue_imm),
      .d_entry       (bus.issue_entry),
      .d_qj_busy     (bus.issue_qj_busy),
      .d_qj          (bus.issue_qj),
      .d_vj          (bus.issue_vj),
      .d_qk_busy     (bus.issue_qk_busy),
      .d_qk          (bus.issue_qk),
      .d_vk          (bus.issue_vk),
      .alu_broadcast (bus.alu_broadcast),
      .alu_result    (bus.alu_result),
      .alu_entry     (bus.alu_entry),
      .lsb_broadcast (bus.lsb_broadcast),
      .lsb_result    (bus.lsb_result),
      .lsb_entry     (bus.lsb_entry),
      .busy          (busy[g]),
      .ready         (ready[g]),
      .instruction   (e_instruction[g]),
      .op            (e_op[g]),
      .pc            (e_pc[g]),
      .imm           (e_imm[g]),
      .entry         (e_entry[g]),
      .vj            (e_vj[g]),
      .vk            (e_vk[g])
    );
  end

  assign bus.rs_full = &busy;

  // Output stage: data registers only move on an issue, so they hold
  // through idle cycles, flushes and freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.new_calculate <= 1'b0;
      bus.instruction   <= '0;
      bus.op            <= '0;
      bus.vj            <= '0;
      bus.vk            <= '0;
      bus.pc            <= '0;
      bus.imm           <= '0;
      bus.entry         <= '0;
    end else if (clear || !rdy) begin
      bus.new_calculate <= 1'b0;
    end else begin
      bus.new_calculate <= sel_vld;
      if (sel_vld) begin
        bus.instruction <= e_instruction[sel_idx];
        bus.op          <= e_op[sel_idx];
        bus.vj          <= e_vj[sel_idx];
        bus.vk          <= e_vk[sel_idx];
        bus.pc          <= e_pc[sel_idx];
        bus.imm         <= e_imm[sel_idx];
        bus.entry       <= e_entry[sel_idx];
      end
    end
  end
endmodule

// File: tb/tb_rs_alu.sv
module tb_rs_alu;
  logic clk = 1'b0;
  logic rst, rdy, clear;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;

  rs_alu_if #(.TAG_W(4)) bus ();

  rs_alu #(.RS_SIZE(16), .RS_IDX_W(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic        busy;
    logic [31:0] ins, pc, imm;
    logic [5:0]  op;
    logic [3:0]  ent;
    logic        qjb, qkb;
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
  } ment_t;

  typedef struct {
    int          cyc;
    logic [31:0] ins, pc, imm, vj, vk;
    logic [5:0]  op;
    logic [3:0]  ent;
  } exp_t;

  ment_t m[16];
  exp_t  q[$];
  exp_t  last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Value carried by either CDB for a tag; ALU bus takes precedence.
  task automatic snoop(input logic [3:0] tag, output logic hit, output logic [31:0] val);
    hit = 1'b0;
    val = 32'd0;
    if (bus.lsb_broadcast && bus.lsb_entry == tag) begin hit = 1'b1; val = bus.lsb_result; end
    if (bus.alu_broadcast && bus.alu_entry == tag) begin hit = 1'b1; val = bus.alu_result; end
  endtask

  // Predicts what the coming clock edge does given the inputs now applied.
  task automatic model_step();
    int sel, fr;
    logic h;
    logic [31:0] v;
    exp_t e;
    if (rst) begin
      foreach (m[i]) m[i].busy = 1'b0;
      last = '{default: 0};
      return;
    end
    if (clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      return;
    end
    if (!rdy) return;
    sel = -1;
    fr  = -1;
    for (int i = 0; i < 16; i++) begin
      if (sel < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy && m[i].qjb) begin
        snoop(m[i].qj, h, v);
        if (h) begin m[i].vj = v; m[i].qjb = 1'b0; end
      end
      if (m[i].busy && m[i].qkb) begin
        snoop(m[i].qk, h, v);
        if (h) begin m[i].vk = v; m[i].qkb = 1'b0; end
      end
    end
    if (sel >= 0) begin
      e.cyc = cyc + 1;
      e.ins = m[sel].ins; e.op = m[sel].op; e.pc = m[sel].pc; e.imm = m[sel].imm;
      e.ent = m[sel].ent; e.vj = m[sel].vj; e.vk = m[sel].vk;
      q.push_back(e);
      last = e;
      m[sel].busy = 1'b0;
    end
    if (bus.issue_valid && fr >= 0) begin
      m[fr].busy = 1'b1;
      m[fr].ins = bus.issue_instruction; m[fr].op = bus.issue_op;
      m[fr].pc = bus.issue_pc; m[fr].imm = bus.issue_imm; m[fr].ent = bus.issue_entry;
      m[fr].qj = bus.issue_qj; m[fr].qk = bus.issue_qk;
      snoop(bus.issue_qj, h, v);
      m[fr].qjb = bus.issue_qj_busy && !h;
      m[fr].vj  = (bus.issue_qj_busy && h) ? v : bus.issue_vj;
      snoop(bus.issue_qk, h, v);
      m[fr].qkb = bus.issue_qk_busy && !h;
      m[fr].vk  = (bus.issue_qk_busy && h) ? v : bus.issue_vk;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic chk_out(input string pfx, input exp_t e);
    chk({pfx, "instruction"}, bus.instruction, e.ins);
    chk({pfx, "op"},          32'(bus.op),     32'(e.op));
    chk({pfx, "vj"},          bus.vj,          e.vj);
    chk({pfx, "vk"},          bus.vk,          e.vk);
    chk({pfx, "pc"},          bus.pc,          e.pc);
    chk({pfx, "imm"},         bus.imm,         e.imm);
    chk({pfx, "entry"},       32'(bus.entry),  32'(e.ent));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.new_calculate === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_new_calculate", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk_out("", e);
        end
      end else begin
        chk("new_calculate_x", 32'(bus.new_calculate), 32'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("missing_issue_at_cycle", 32'd0, e.cyc);
        end
        chk_out("hold_", last);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_idle();
    rdy = 1'b1; clear = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_instruction = '0; bus.issue_op = '0;
    bus.issue_pc = '0; bus.issue_imm = '0; bus.issue_entry = '0;
    bus.issue_qj_busy = 1'b0; bus.issue_qj = '0; bus.issue_vj = '0;
    bus.issue_qk_busy = 1'b0; bus.issue_qk = '0; bus.issue_vk = '0;
    bus.alu_broadcast = 1'b0; bus.alu_result = '0; bus.alu_entry = '0;
    bus.lsb_broadcast = 1'b0; bus.lsb_result = '0; bus.lsb_entry = '0;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic tick();
    if (!rst) chk("rs_full", 32'(bus.rs_full), 32'(model_full()));
    model_step();
    @(negedge clk);
    set_idle();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put_op(input logic [5:0] op, input logic [3:0] ent,
                        input logic qjb, input logic [3:0] qj, input logic [31:0] vj,
                        input logic qkb, input logic [3:0] qk, input logic [31:0] vk);
    bus.issue_valid = 1'b1;
    bus.issue_instruction = $urandom; bus.issue_pc = $urandom; bus.issue_imm = $urandom;
    bus.issue_op = op; bus.issue_entry = ent;
    bus.issue_qj_busy = qjb; bus.issue_qj = qj; bus.issue_vj = vj;
    bus.issue_qk_busy = qkb; bus.issue_qk = qk; bus.issue_vk = vk;
  endtask

  initial begin
    foreach (m[i]) m[i] = '{default: 0};
    last = '{default: 0};
    set_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle_n(2);

    // Ready ADDI: vj=5, imm=7, tag 3; ALU result 12 appears on its CDB afterwards.
    put_op(6'd1, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
    bus.issue_imm = 32'd7;
    tick();
    tick();
    bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd3; bus.alu_result = 32'd12;
    tick();
    idle_n(2);

    // ADD waiting on tag 2 for rs1, vk=1; ALU broadcasts 9 on tag 2.
    put_op(6'd2, 4'd5, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1);
    tick();
    idle_n(2);
    bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd2; bus.alu_result = 32'd9;
    tick();
    idle_n(3);

    // rs2 pending on tag 6 while load/store CDB delivers 0xDEAD the same cycle.
    put_op(6'd3, 4'd7, 1'b0, 4'd0, 32'd4, 1'b1, 4'd6, 32'd0);
    bus.lsb_broadcast = 1'b1; bus.lsb_entry = 4'd6; bus.lsb_result = 32'hDEAD;
    tick();
    idle_n(3);

    // Fill all slots waiting on tag 1, stray dispatch while full, then wake all.
    for (int i = 0; i < 16; i++) begin
      put_op(6'(i), 4'(i), 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(100 + i));
      tick();
    end
    put_op(6'd63, 4'd15, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    tick();
    bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd1; bus.alu_result = 32'h1111;
    tick();
    idle_n(18);

    // Flush with 5 pending entries plus a concurrent ready dispatch.
    for (int i = 0; i < 5; i++) begin
      put_op(6'd4, 4'(8 + i), 1'b1, 4'd4, 32'd0, 1'b1, 4'd9, 32'd0);
      tick();
    end
    put_op(6'd5, 4'd2, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
    clear = 1'b1;
    tick();
    bus.alu_broadcast = 1'b1; bus.alu_entry = 4'd4; bus.alu_result = 32'd1;
    bus.lsb_broadcast = 1'b1; bus.lsb_entry = 4'd9; bus.lsb_result = 32'd2;
    tick();
    idle_n(3);

    // Freeze for 3 cycles with a ready entry present.
    put_op(6'd6, 4'd11, 1'b0, 4'd0, 32'd21, 1'b0, 4'd0, 32'd22);
    tick();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0;
      tick();
    end
    idle_n(3);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 1) == 1 && (!model_full() || $urandom_range(0, 3) == 0))
        put_op(6'($urandom), 4'($urandom),
               $urandom_range(0, 2) == 0, 4'($urandom), $urandom,
               $urandom_range(0, 2) == 0, 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        bus.alu_broadcast = 1'b1; bus.alu_entry = 4'($urandom); bus.alu_result = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.lsb_broadcast = 1'b1; bus.lsb_entry = 4'($urandom); bus.lsb_result = $urandom;
      end
      clear = ($urandom_range(0, 60) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      tick();
    end
    idle_n(20);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
